alu_share_arbiter: RTL

- Shares the single combinational alu datapath between two requesters: port 0 is the CPU execute stage, port 1 is the neuron-update engine.
- Round-robin arbitration with a valid/ready request and response handshake per port.
- Holds the ALU operands stable for a multi-cycle window on MUL/DIV/REM select codes, which are a timed multicycle path.
- Registers the result and returns it to the owning requester.
- Sits between the requesters and one alu instance; owns the ALU's DATA1/DATA2/SELECT inputs.

---
 rtl/alu_share_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the CPU execute stage (port 0)
// and the neuron-update engine (port 1); holds operands for a multicycle window per op.
module alu_share_arbiter #(
    parameter int unsigned BASE_CYCLES   = 1,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,

    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [31:0] REQ0_DATA1,
    input  logic [31:0] REQ0_DATA2,
    input  logic [5:0]  REQ0_SELECT,
    output logic        RSP0_VALID,
    input  logic        RSP0_READY,
    output logic [31:0] RSP0_RESULT,

    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [31:0] REQ1_DATA1,
    input  logic [31:0] REQ1_DATA2,
    input  logic [5:0]  REQ1_SELECT,
    output logic        RSP1_VALID,
    input  logic        RSP1_READY,
    output logic [31:0] RSP1_RESULT,

    output logic [31:0] ALU_DATA1,
    output logic [31:0] ALU_DATA2,
    output logic [5:0]  ALU_SELECT,
    input  logic [31:0] ALU_RESULT,

    output logic        BUSY
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SEL_W      = 6;
    localparam int unsigned MAX_CYCLES = (BASE_CYCLES > MULDIV_CYCLES) ? BASE_CYCLES : MULDIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BASE_LOAD   = CNT_W'(BASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } op_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_t               op_q, op_d;
    logic [DATA_W-1:0] rsp0_res_q, rsp0_res_d;
    logic [DATA_W-1:0] rsp1_res_q, rsp1_res_d;

    logic              grant0;
    logic              grant1;
    logic              owner_rsp_ready;

    // mul/div/rem group (SELECT[5:3] == 3'b001) gets the long window
    function automatic logic [CNT_W-1:0] cycle_load(input logic [SEL_W-1:0] sel);
        return (sel[5:3] == 3'b001) ? MULDIV_LOAD : BASE_LOAD;
    endfunction

    // Tie goes to the port that was not served last
    always_comb begin
        grant0 = REQ0_VALID && (!REQ1_VALID || last_grant_q);
        grant1 = REQ1_VALID && (!REQ0_VALID || !last_grant_q);
    end

    assign REQ0_READY      = (state_q == IDLE) && grant0;
    assign REQ1_READY      = (state_q == IDLE) && grant1;
    assign owner_rsp_ready = owner_q ? RSP1_READY : RSP0_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            op_q         <= '0;
            rsp0_res_q   <= '0;
            rsp1_res_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp1_res_q   <= rsp1_res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rsp0_res_d   = rsp0_res_q;
        rsp1_res_d   = rsp1_res_q;

        case (state_q)
            IDLE: begin
                if (REQ0_READY) begin
                    op_d    = '{sel: REQ0_SELECT, d1: REQ0_DATA1, d2: REQ0_DATA2};
                    owner_d = 1'b0;
                    cnt_d   = cycle_load(REQ0_SELECT);
                    state_d = EXEC;
                end else if (REQ1_READY) begin
                    op_d    = '{sel: REQ1_SELECT, d1: REQ1_DATA1, d2: REQ1_DATA2};
                    owner_d = 1'b1;
                    cnt_d   = cycle_load(REQ1_SELECT);
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        rsp1_res_d = ALU_RESULT;
                    end else begin
                        rsp0_res_d = ALU_RESULT;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                if (owner_rsp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ALU inputs come only from the operand register, so they stay put for the window
    assign ALU_DATA1  = op_q.d1;
    assign ALU_DATA2  = op_q.d2;
    assign ALU_SELECT = op_q.sel;

    assign RSP0_VALID  = (state_q == RESP) && !owner_q;
    assign RSP1_VALID  = (state_q == RESP) && owner_q;
    assign RSP0_RESULT = rsp0_res_q;
    assign RSP1_RESULT = rsp1_res_q;
    assign BUSY        = (state_q != IDLE);

endmodule
